// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchronizer plus an independent stability counter per switch bit.
// The debounced level and its rise/fall/any-change strobes are all registered.
`timescale 1ns/1ps
module sw_debounce #(
   parameter int WIDTH   = 10,
   parameter int CNT_MAX = 500000,
   parameter int CNT_W   = 19
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [WIDTH-1:0] BITS_ZERO = {WIDTH{1'b0}};

   logic [WIDTH-1:0]            sync1_q, sync1_d;
   logic [WIDTH-1:0]            sync2_q, sync2_d;
   logic [WIDTH-1:0]            stable_q, stable_d;
   logic [WIDTH-1:0]            rise_q, rise_d;
   logic [WIDTH-1:0]            fall_q, fall_d;
   logic                        changed_q, changed_d;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: any return to the stable level restarts qualification from zero.
   always_comb begin
      sync1_d  = SW;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = CNT_ZERO;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = CNT_ZERO;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
      rise_d    = stable_d & ~stable_q;
      fall_d    = ~stable_d & stable_q;
      changed_d = |(rise_d | fall_d);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         sync1_q   <= BITS_ZERO;
         sync2_q   <= BITS_ZERO;
         stable_q  <= BITS_ZERO;
         rise_q    <= BITS_ZERO;
         fall_q    <= BITS_ZERO;
         changed_q <= 1'b0;
         cnt_q     <= {WIDTH{CNT_ZERO}};
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         stable_q  <= stable_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
         cnt_q     <= cnt_d;
      end
   end

   assign sw_stable  = stable_q;
   assign sw_rise    = rise_q;
   assign sw_fall    = fall_q;
   assign sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (CNT_MAX=4): vector table, directed corner sequences, and a
// randomized run against a sample-window reference model.
`timescale 1ns/1ps
module tb_sw_debounce;
   localparam int WIDTH   = 10;
   localparam int CNT_MAX = 4;
   localparam int CNT_W   = 3;

   logic             clk;
   logic             resetn;
   logic [WIDTH-1:0] sw;
   logic [WIDTH-1:0] sw_stable, sw_rise, sw_fall;
   logic             sw_changed;

   int n_cmp  = 0;
   int n_fail = 0;

   sw_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
      .CLOCK_50  (clk),
      .resetn    (resetn),
      .SW        (sw),
      .sw_stable (sw_stable),
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall),
      .sw_changed(sw_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             rst_n;
      logic [WIDTH-1:0] sw;
      logic [WIDTH-1:0] st;
      logic [WIDTH-1:0] ri;
      logic [WIDTH-1:0] fa;
      logic             ch;
   } vec_t;
   vec_t tbl[$];

   // Reference: a bit flips when the last CNT_MAX synchronized samples all differ from it.
   logic [WIDTH-1:0] m_hist[$];
   logic [WIDTH-1:0] m_stable, m_rise, m_fall;
   logic             m_chg;

   task automatic model_reset();
      m_hist.delete();
      for (int k = 0; k <= CNT_MAX; k++) m_hist.push_back({WIDTH{1'b0}});
      m_stable = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
   endtask

   task automatic model_step(input logic rst_n, input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] nxt, h;
      bit all_diff;
      if (!rst_n) begin
         model_reset();
      end else begin
         nxt = m_stable;
         for (int i = 0; i < WIDTH; i++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= CNT_MAX; k++) begin
               h = m_hist[k];
               if (h[i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) nxt[i] = ~m_stable[i];
         end
         m_rise   = nxt & ~m_stable;
         m_fall   = ~nxt & m_stable;
         m_chg    = |(m_rise | m_fall);
         m_stable = nxt;
         m_hist.push_front(s);
         void'(m_hist.pop_back());
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick(input logic rst_n, input logic [WIDTH-1:0] s);
      resetn = rst_n;
      sw     = s;
      @(posedge clk);
      model_step(rst_n, s);
      #1;
      check("model", {1'b0, sw_stable, sw_rise, sw_fall, sw_changed},
            {1'b0, m_stable, m_rise, m_fall, m_chg});
   endtask

   task automatic add(input logic r, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] st,
                      input logic [WIDTH-1:0] ri, input logic [WIDTH-1:0] fa, input logic ch);
      vec_t v;
      v.rst_n = r; v.sw = s; v.st = st; v.ri = ri; v.fa = fa; v.ch = ch;
      tbl.push_back(v);
   endtask

   initial begin
      int n, rises;
      logic [WIDTH-1:0] cur, acc;
      logic [31:0] r;

      model_reset();
      resetn = 1'b0;
      sw     = 10'h3FF;

      // Reset, power-up qualification, full release, clean single-bit press.
      for (int k = 0; k < 3; k++) add(1'b0, 10'h3FF, 10'h000, 10'h000, 10'h000, 1'b0);
      for (int k = 0; k < 5; k++) add(1'b1, 10'h3FF, 10'h000, 10'h000, 10'h000, 1'b0);
      add(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000, 1'b1);
      add(1'b1, 10'h3FF, 10'h3FF, 10'h000, 10'h000, 1'b0);
      for (int k = 0; k < 5; k++) add(1'b1, 10'h000, 10'h3FF, 10'h000, 10'h000, 1'b0);
      add(1'b1, 10'h000, 10'h000, 10'h000, 10'h3FF, 1'b1);
      add(1'b1, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0);
      for (int k = 0; k < 5; k++) add(1'b1, 10'h001, 10'h000, 10'h000, 10'h000, 1'b0);
      add(1'b1, 10'h001, 10'h001, 10'h001, 10'h000, 1'b1);
      add(1'b1, 10'h001, 10'h001, 10'h000, 10'h000, 1'b0);

      for (int idx = 0; idx < tbl.size(); idx++) begin
         tick(tbl[idx].rst_n, tbl[idx].sw);
         check($sformatf("tbl%0d_stable", idx), {22'd0, sw_stable}, {22'd0, tbl[idx].st});
         check($sformatf("tbl%0d_rise", idx), {22'd0, sw_rise}, {22'd0, tbl[idx].ri});
         check($sformatf("tbl%0d_fall", idx), {22'd0, sw_fall}, {22'd0, tbl[idx].fa});
         check($sformatf("tbl%0d_changed", idx), {31'd0, sw_changed}, {31'd0, tbl[idx].ch});
      end

      // Bounce on SW[9]: 1,0,1,0 then held 1.
      rises = 0;
      tick(1'b1, 10'h201); rises += int'(sw_rise[9]);
      tick(1'b1, 10'h001); rises += int'(sw_rise[9]);
      tick(1'b1, 10'h201); rises += int'(sw_rise[9]);
      tick(1'b1, 10'h001); rises += int'(sw_rise[9]);
      tick(1'b1, 10'h201); rises += int'(sw_rise[9]);
      n = 1;
      while (!sw_stable[9] && n < 20) begin
         tick(1'b1, 10'h201); rises += int'(sw_rise[9]); n++;
      end
      check("bounce_latency", n, 32'd6);
      repeat (3) begin tick(1'b1, 10'h201); rises += int'(sw_rise[9]); end
      check("bounce_rise_count", rises, 32'd1);

      // Glitch on SW[4] lasting CNT_MAX-1 samples.
      acc = '0;
      repeat (3) begin tick(1'b1, 10'h211); acc |= sw_rise | sw_fall | {9'd0, sw_changed} | (sw_stable & 10'h010); end
      repeat (10) begin tick(1'b1, 10'h201); acc |= sw_rise | sw_fall | {9'd0, sw_changed} | (sw_stable & 10'h010); end
      check("glitch_quiet", {22'd0, acc}, 32'd0);

      // Simultaneous rise of [3:0] and fall of [7:4].
      repeat (8) tick(1'b1, 10'h0F0);
      check("simul_base", {22'd0, sw_stable}, 32'h0F0);
      tick(1'b1, 10'h00F);
      n = 1;
      while (!sw_changed && n < 12) begin tick(1'b1, 10'h00F); n++; end
      check("simul_latency", n, 32'd6);
      check("simul_rise", {22'd0, sw_rise}, 32'h00F);
      check("simul_fall", {22'd0, sw_fall}, 32'h0F0);
      check("simul_changed", {31'd0, sw_changed}, 32'd1);
      tick(1'b1, 10'h00F);
      check("simul_pulse_end", {1'b0, sw_rise, sw_fall, sw_changed}, {1'b0, 10'h000, 10'h000, 1'b0});

      // Reset while SW[1] is partway through qualification.
      repeat (8) tick(1'b1, 10'h000);
      check("midrst_base", {22'd0, sw_stable}, 32'd0);
      repeat (4) tick(1'b1, 10'h002);
      tick(1'b0, 10'h002);
      check("midrst_outputs", {1'b0, sw_stable, sw_rise, sw_fall, sw_changed}, 32'd0);
      tick(1'b1, 10'h002);
      n = 1;
      while (!sw_stable[1] && n < 20) begin tick(1'b1, 10'h002); n++; end
      check("midrst_latency", n, 32'd6);
      check("midrst_rise", {31'd0, sw_rise[1]}, 32'd1);

      // Randomized switch activity with occasional resets.
      cur = 10'h002;
      for (int t = 0; t < 800; t++) begin
         r = $urandom & $urandom & $urandom;
         cur = cur ^ r[WIDTH-1:0];
         tick(($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0, cur);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 6)) tick(1'b1, cur);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
